// File: rtl/mdu_if.sv
// MDU request/result handshake bundle.
// EXU side is master, MDU side is slave.
interface mdu_if #(
  parameter int W = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_opt;
  logic [W-1:0] i_src1;
  logic [W-1:0] i_src2;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_res;
  logic         o_busy;

  modport slave (
    input  i_valid, i_opt, i_src1, i_src2,
    input  i_flush, i_ready,
    output o_ready, o_valid, o_res, o_busy
  );

  modport master (
    output i_valid, i_opt, i_src1, i_src2,
    output i_flush, i_ready,
    input  o_ready, o_valid, o_res, o_busy
  );
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide unit: shift-add
// multiply and restoring divide, 1 bit/cycle.
module mdu #(
  parameter int CPU_WIDTH = 32
) (
  input logic i_clk,
  input logic i_rst,
  mdu_if.slave bus
);
  localparam int W  = CPU_WIDTH;
  localparam int CB = $clog2(W);

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state, state_nxt;

  logic [CB-1:0]  cnt;
  logic [2:0]     opt;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] acc;
  logic           neg_res;
  logic           neg_rem;
  logic [W-1:0]   res;

  logic accept;
  logic sgn1, sgn2, n1, n2;
  logic [W-1:0] abs1, abs2;
  logic div_zero, div_ovf, special;
  logic [W-1:0] sp_res;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_acc;
  logic [W:0]     div_sh;
  logic [W:0]     div_sub;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] div_acc;
  logic [2*W-1:0] step_acc;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic [W-1:0]   fin_res;

  assign bus.o_ready = (state == IDLE)
                     && !bus.i_flush;
  assign bus.o_valid = (state == DONE);
  assign bus.o_busy  = (state != IDLE);
  assign bus.o_res   = res;
  assign accept = bus.i_valid && bus.o_ready;

  // Operand signedness, magnitudes and special divides
  always_comb begin
    sgn1 = bus.i_opt[2] ? !bus.i_opt[0]
                        : (bus.i_opt[1:0] != 2'b11);
    sgn2 = bus.i_opt[2] ? !bus.i_opt[0]
                        : !bus.i_opt[1];
    n1   = sgn1 && bus.i_src1[W-1];
    n2   = sgn2 && bus.i_src2[W-1];
    abs1 = n1 ? -bus.i_src1 : bus.i_src1;
    abs2 = n2 ? -bus.i_src2 : bus.i_src2;
    div_zero = bus.i_opt[2]
            && (bus.i_src2 == '0);
    div_ovf  = bus.i_opt[2] && !bus.i_opt[0]
            && (bus.i_src1 == {1'b1, {(W-1){1'b0}}})
            && (bus.i_src2 == '1);
    special  = div_zero || div_ovf;
    sp_res   = '0;
    if (div_zero)
      sp_res = bus.i_opt[1] ? bus.i_src1 : '1;
    else if (div_ovf)
      sp_res = bus.i_opt[1] ? '0
                            : {1'b1, {(W-1){1'b0}}};
  end

  // One iteration of multiply or divide, plus
  // sign correction and result selection
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]}
            + (acc[0] ? {1'b0, a} : '0);
    mul_acc = {mul_sum, acc[W-1:1]};
    div_sh  = {acc[2*W-1:W], acc[W-1]};
    div_sub = div_sh - {1'b0, b};
    div_ge  = !div_sub[W];
    div_rem = div_ge ? div_sub[W-1:0]
                     : div_sh[W-1:0];
    div_acc = {div_rem, acc[W-2:0], div_ge};
    step_acc = (state == DIV) ? div_acc : mul_acc;
    prod = neg_res ? -step_acc : step_acc;
    quot = neg_res ? -step_acc[W-1:0]
                   : step_acc[W-1:0];
    rem  = neg_rem ? -step_acc[2*W-1:W]
                   : step_acc[2*W-1:W];
    fin_res = '0;
    unique case (1'b1)
      opt[2] &&  opt[1]:   fin_res = rem;
      opt[2] && !opt[1]:   fin_res = quot;
      !opt[2] && (opt[1:0] == 2'b00):
                           fin_res = prod[W-1:0];
      !opt[2] && (opt[1:0] != 2'b00):
                           fin_res = prod[2*W-1:W];
      default:             fin_res = '0;
    endcase
  end

  // Next-state logic; flush always wins
  always_comb begin
    state_nxt = state;
    if (bus.i_flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept)
          state_nxt = special ? DONE
                    : (bus.i_opt[2] ? DIV : MUL);
        MUL, DIV: if (cnt == CB'(W-1))
          state_nxt = DONE;
        DONE: if (bus.i_ready)
          state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture, iteration and result register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      opt     <= '0;
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      res     <= '0;
    end else if (accept) begin
      cnt     <= '0;
      opt     <= bus.i_opt;
      a       <= abs1;
      b       <= abs2;
      acc     <= {{W{1'b0}},
                  bus.i_opt[2] ? abs1 : abs2};
      neg_res <= n1 ^ n2;
      neg_rem <= n1;
      if (special) res <= sp_res;
    end else if (state == MUL
              || state == DIV) begin
      cnt <= cnt + 1'b1;
      acc <= step_acc;
      if (cnt == CB'(W-1) && !bus.i_flush)
        res <= fin_res;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for the iterative
// multiply/divide unit.
module tb_mdu;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mdu_if #(.W(32)) bus ();

  mdu #(.CPU_WIDTH(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Issue one op, wait for result, optionally
  // hold off i_ready, then complete handshake.
  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] s1,
                        input logic [31:0] s2,
                        input logic [31:0] exp,
                        input int lat,
                        input int hold);
    int n;
    @(negedge i_clk);
    chk({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_opt   = op;
    bus.i_src1  = s1;
    bus.i_src2  = s2;
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    bus.i_src1  = $urandom;
    bus.i_src2  = $urandom;
    bus.i_opt   = 3'($urandom);
    n = 0;
    while (!bus.o_valid && n < 100) begin
      if (n == 5)
        chk({tag, "_busy"},
            32'(bus.o_busy), 32'd1);
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, bus.o_res, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      chk({tag, "_hold"}, bus.o_res, exp);
      chk({tag, "_hrdy"},
          32'({bus.o_valid, bus.o_ready}),
          32'b10);
    end
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    chk({tag, "_idle"},
        32'({bus.o_valid, bus.o_ready,
             bus.o_busy}), 32'b010);
  endtask

  // Start a DIV and abort it at iteration 10
  task automatic abort_div(input bit use_rst);
    int seen;
    @(negedge i_clk);
    bus.i_valid = 1'b1;
    bus.i_opt   = 3'b100;
    bus.i_src1  = 32'd1000;
    bus.i_src2  = 32'd7;
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    chk("ab_busy", 32'(bus.o_busy), 32'd1);
    if (use_rst) begin
      i_rst = 1'b1;
      #1;
      chk("rs_now",
          32'({bus.o_busy, bus.o_valid,
               bus.o_ready}), 32'b001);
      chk("rs_res", bus.o_res, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
    end else begin
      bus.i_flush = 1'b1;
      #1;
      chk("fl_rdy", 32'(bus.o_ready), 32'd0);
      @(negedge i_clk);
      bus.i_flush = 1'b0;
      chk("fl_idle",
          32'({bus.o_busy, bus.o_valid}),
          32'b00);
    end
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (bus.o_valid) seen++;
    end
    chk("ab_noval", seen, 0);
    run_op("ab_mul", 3'b000, 32'd3, 32'd4,
           32'd12, 32, 0);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_opt   = 3'b000;
    bus.i_src1  = '0;
    bus.i_src2  = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    #1;
    chk("rst_out",
        32'({bus.o_ready, bus.o_valid,
             bus.o_busy}), 32'b100);
    chk("rst_res", bus.o_res, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_op("mul", 3'b000, 32'd7,
           32'hFFFFFFFD, 32'hFFFFFFEB, 32, 0);
    run_op("mulh", 3'b001, 32'h80000000,
           32'h80000000, 32'h40000000, 32, 0);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32, 0);
    run_op("mul_big", 3'b000, 32'h00012345,
           32'h00010000, 32'h23450000, 32, 0);
    run_op("div", 3'b100, 32'hFFFFFFF9,
           32'd2, 32'hFFFFFFFD, 32, 0);
    run_op("rem", 3'b110, 32'hFFFFFFF9,
           32'd2, 32'hFFFFFFFF, 32, 0);
    run_op("divu", 3'b101, 32'hFFFFFFF9,
           32'd2, 32'h7FFFFFFC, 32, 0);
    run_op("remu", 3'b111, 32'd100,
           32'd7, 32'd2, 32, 0);
    run_op("div_nd", 3'b100, 32'd20,
           32'hFFFFFFFD, 32'hFFFFFFFA, 32, 0);
    run_op("rem_nd", 3'b110, 32'd20,
           32'hFFFFFFFD, 32'd2, 32, 0);
    run_op("divu_z", 3'b101, 32'd5,
           32'd0, 32'hFFFFFFFF, 0, 0);
    run_op("rem_z", 3'b110, 32'd5,
           32'd0, 32'd5, 0, 0);
    run_op("div_ov", 3'b100, 32'h80000000,
           32'hFFFFFFFF, 32'h80000000, 0, 0);
    run_op("rem_ov", 3'b110, 32'h80000000,
           32'hFFFFFFFF, 32'd0, 0, 0);
    run_op("bp", 3'b101, 32'd1000,
           32'd10, 32'd100, 32, 5);
    run_op("b2b", 3'b000, 32'd6,
           32'd7, 32'd42, 32, 0);

    abort_div(1'b0);
    abort_div(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter: CPU_WIDTH, 32, operand/result width; all concrete values below are for 32.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: i_valid  input  1  request valid from EXU.
REQ-005 SHALL have port: o_ready  output  1  request accepted when i_valid && o_ready at a rising edge.
REQ-006 SHALL have port: i_opt  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port: i_src1  input  CPU_WIDTH  multiplicand/dividend.
REQ-008 SHALL have port: i_src2  input  CPU_WIDTH  multiplier/divisor.
REQ-009 SHALL have port: i_flush  input  1  abort any in-flight operation.
REQ-010 SHALL have port: o_valid  output  1  result valid.
REQ-011 SHALL have port: i_ready  input  1  result consumed when o_valid && i_ready at a rising edge.
REQ-012 SHALL have port: o_res  output  CPU_WIDTH  result.
REQ-013 SHALL have port: o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE; o_ready = (state==IDLE) && !i_flush.
REQ-015 SHALL, on accept, register i_opt, i_src1 and i_src2, and ignore subsequent input changes until the next accept.
REQ-016 SHALL, on accept of opt 0xx, enter MUL with iteration counter 0.
REQ-017 SHALL, on accept of opt 1xx, enter DIV with iteration counter 0, except for the special cases in REQ-024/025.
REQ-018 SHALL compute MUL by unsigned shift-add, 1 bit per cycle, 32 iterations over the absolute values of the operands, producing a 64-bit product.
REQ-019 SHALL compute DIV by unsigned restoring division, 1 quotient bit per cycle, 32 iterations, producing a 32-bit quotient and 32-bit remainder.
REQ-020 SHALL transition to DONE on the edge that completes iteration 32, so o_valid is high exactly 32 cycles after the accept edge.
REQ-021 SHALL apply signedness as follows: MUL/MULH treat both operands as signed; MULHSU treats src1 as signed and src2 as unsigned; MULHU/DIVU/REMU treat both as unsigned; DIV/REM treat both as signed.
REQ-022 SHALL correct signs as follows: product negated when the operand signs differ; quotient negated when the signs differ; remainder takes the sign of the dividend.
REQ-023 SHALL select o_res as: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-024 SHALL handle divide by zero (src2==0) as follows: DIV/DIVU return 0xFFFFFFFF; REM/REMU return src1; go IDLE->DONE at the accept edge (1-cycle latency).
REQ-025 SHALL handle signed overflow (DIV/REM with src1=0x80000000, src2=0xFFFFFFFF) as follows: DIV returns 0x80000000; REM returns 0; 1-cycle latency.
REQ-026 SHALL, in DONE, hold o_valid high and o_res stable until i_ready; the handshake edge returns to IDLE; no new accept is possible in DONE.
REQ-027 SHALL, when i_flush=1 at any edge, force the next state to IDLE and clear o_valid; flush overrides a simultaneous accept or result handshake.
REQ-028 SHALL hold o_res at its last value outside DONE; o_res is don't-care when o_valid=0.

Reset
REQ-029 SHALL, while i_rst=1, immediately force state IDLE, counter 0, o_valid 0, o_busy 0, o_res 0, and all operand/accumulator registers 0; o_ready=1.
REQ-030 SHALL, on reset asserted mid-operation, discard the operation with no o_valid pulse; the first accept after reset release SHALL compute correctly.

Verification
REQ-031 SHALL verify MUL with src1=7, src2=0xFFFFFFFD: o_res=0xFFFFFFEB; o_valid rises exactly 32 cycles after accept; o_busy high throughout.
REQ-032 SHALL verify MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 SHALL verify DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9,2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU 100,7 -> 2.
REQ-034 SHALL verify special cases: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each o_valid the cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-035 SHALL verify backpressure: i_ready held low 5 cycles after o_valid -> o_res stable, o_ready=0; i_ready=1 -> handshake; o_ready=1 next cycle; a back-to-back op then completes correctly.
REQ-036 SHALL verify abort: i_flush (then separately i_rst) asserted at iteration 10 of a DIV -> IDLE next edge (immediately for reset), no o_valid; a following MUL 3*4 -> 12.
